// File: rtl/glyph_row_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// glyph_row_fetch_scheduler
//
// Shares one synchronous glyph word ROM among NUM_GLYPHS row requesters.
// Each requester pulses req[g] with a row index and base address. The request
// is held pending until a round-robin grant picks it. The granted row is then
// fetched as WORDS_PER_ROW consecutive ROM words. The words are packed
// MSB-first into rowData, and a one-hot rowValid pulse names the glyph that
// owns the row.
//
// Ports
//   clk           pixel clock, single clock domain
//   reset         synchronous, active-high
//   req           per-glyph row request pulse
//   rowIndexFlat  glyph g row index at [4g+3:4g], sampled with req[g]
//   baseFlat      glyph g base address at [ADDR_W*g +: ADDR_W], sampled with req[g]
//   rom_addr      ROM address, combinational from registered state (0 when not fetching)
//   rom_q         ROM data, valid one cycle after rom_addr
//   rowData       completed row, registered, held between pulses
//   rowValid      one-hot single-cycle pulse marking the owner of rowData
//   busy          high whenever the scheduler is not idle
//   overrun       (only with GLYPH_SCHED_OVERRUN_EN) sticky per-glyph flag set
//                 when a request lands on a glyph that is still pending or in flight
//
// Optional feature macro: GLYPH_SCHED_OVERRUN_EN
// ---------------------------------------------------------------------------
module glyph_row_fetch_scheduler #(
  parameter int NUM_GLYPHS    = 5,
  parameter int ADDR_W        = 10,
  parameter int WORD_W        = 16,
  parameter int WORDS_PER_ROW = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_GLYPHS-1:0]           req,
  input  logic [NUM_GLYPHS*4-1:0]         rowIndexFlat,
  input  logic [NUM_GLYPHS*ADDR_W-1:0]    baseFlat,
  output logic [ADDR_W-1:0]               rom_addr,
  input  logic [WORD_W-1:0]               rom_q,
  output logic [WORDS_PER_ROW*WORD_W-1:0] rowData,
  output logic [NUM_GLYPHS-1:0]           rowValid,
  output logic                            busy
`ifdef GLYPH_SCHED_OVERRUN_EN
  ,
  output logic [NUM_GLYPHS-1:0]           overrun
`endif
);

  localparam int GW    = $clog2(NUM_GLYPHS);
  localparam int ROW_W = WORDS_PER_ROW * WORD_W;
  localparam int EXT_W = ADDR_W + 4;
  localparam int CNT_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_ROW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q;
  logic [NUM_GLYPHS-1:0]   pending_q, pending_d;
  logic [GW-1:0]           last_q;
  logic [GW-1:0]           act_q;
  logic [3:0]              act_idx_q;
  logic [ADDR_W-1:0]       act_base_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    cap_q;
  logic [ROW_W-1:0]        acc_q, acc_d;
  logic [ROW_W-1:0]        rowData_q;
  logic [NUM_GLYPHS-1:0]   rowValid_q;
  logic [3:0]              idx_q  [NUM_GLYPHS];
  logic [ADDR_W-1:0]       base_q [NUM_GLYPHS];

  logic                    gnt_vld;
  logic [GW-1:0]           gnt_idx;
  logic [NUM_GLYPHS-1:0]   gnt_mask;
  logic [EXT_W-1:0]        addr_ext;

  // Round-robin pick: each glyph's distance from last_q+1 (mod NUM_GLYPHS).
  // The nearest pending glyph wins.
  always_comb begin
    int best_d;
    int d;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    best_d  = NUM_GLYPHS;
    d       = 0;
    for (int g = 0; g < NUM_GLYPHS; g++) begin
      d = g - int'(last_q) - 1;
      if (d < 0) d = d + NUM_GLYPHS;
      if (pending_q[g] && (d < best_d)) begin
        best_d  = d;
        gnt_vld = 1'b1;
        gnt_idx = GW'(g);
      end
    end
  end

  assign gnt_mask  = (state_q == S_IDLE && gnt_vld) ? (NUM_GLYPHS'(1) << gnt_idx) : '0;
  // A request in the grant cycle re-arms the glyph, so the set takes priority over the clear.
  assign pending_d = (pending_q & ~gnt_mask) | req;

  // Address arithmetic is done ADDR_W+4 bits wide; the ROM sees it modulo 2^ADDR_W.
  assign addr_ext = EXT_W'(act_base_q) + EXT_W'(act_idx_q) * EXT_W'(WORDS_PER_ROW)
                  + EXT_W'(cnt_q);
  assign rom_addr = (state_q == S_FETCH) ? addr_ext[ADDR_W-1:0] : '0;

  // Each returning word shifts in at the LSB, so word 0 ends up in the MSBs.
  assign acc_d = cap_q ? ((acc_q << WORD_W) | ROW_W'(rom_q)) : acc_q;

  assign rowData  = rowData_q;
  assign rowValid = rowValid_q;
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    // ---- request capture / grant latch (data path, not reset) ----
    for (int g = 0; g < NUM_GLYPHS; g++) begin
      if (req[g]) begin
        idx_q[g]  <= rowIndexFlat[4*g +: 4];
        base_q[g] <= baseFlat[ADDR_W*g +: ADDR_W];
      end
    end
    if (state_q == S_IDLE && gnt_vld) begin
      act_idx_q  <= idx_q[gnt_idx];
      act_base_q <= base_q[gnt_idx];
    end
    acc_q <= acc_d;

    // ---- control FSM and registered outputs ----
    if (reset) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      last_q     <= GW'(NUM_GLYPHS - 1);
      act_q      <= '0;
      cnt_q      <= '0;
      cap_q      <= 1'b0;
      rowValid_q <= '0;
      rowData_q  <= '0;
    end else begin
      rowValid_q <= '0;
      cap_q      <= (state_q == S_FETCH);
      pending_q  <= pending_d;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            act_q   <= gnt_idx;
            last_q  <= gnt_idx;
            cnt_q   <= '0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // The last word arrives in this cycle, so the row is taken from acc_d.
          rowData_q  <= acc_d;
          rowValid_q <= NUM_GLYPHS'(1) << act_q;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef GLYPH_SCHED_OVERRUN_EN
  logic [NUM_GLYPHS-1:0] overrun_q;
  logic [NUM_GLYPHS-1:0] inflight_mask;

  // A glyph counts as in flight from its grant cycle until its DRAIN cycle.
  assign inflight_mask = ((state_q == S_FETCH || state_q == S_DRAIN)
                          ? (NUM_GLYPHS'(1) << act_q) : '0) | gnt_mask;

  always_ff @(posedge clk) begin
    if (reset) overrun_q <= '0;
    else       overrun_q <= overrun_q | (req & (pending_q | inflight_mask));
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_glyph_row_fetch_scheduler.sv
module tb_glyph_row_fetch_scheduler;
  localparam int NG = 5;

  logic           clk;
  logic           reset;
  logic [NG-1:0]  req;
  logic [NG*4-1:0]  rowIndexFlat;
  logic [NG*10-1:0] baseFlat;
  logic [9:0]     rom_addr;
  logic [15:0]    rom_q;
  logic [47:0]    rowData;
  logic [NG-1:0]  rowValid;
  logic           busy;
`ifdef GLYPH_SCHED_OVERRUN_EN
  logic [NG-1:0]  overrun;
`endif

  glyph_row_fetch_scheduler #(
    .NUM_GLYPHS(NG), .ADDR_W(10), .WORD_W(16), .WORDS_PER_ROW(3)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .rowIndexFlat(rowIndexFlat),
    .baseFlat(baseFlat), .rom_addr(rom_addr), .rom_q(rom_q),
    .rowData(rowData), .rowValid(rowValid), .busy(busy)
`ifdef GLYPH_SCHED_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: data equals address, one-cycle latency.
  always @(posedge clk) rom_q <= {6'b0, rom_addr};

  typedef struct {
    int          g;
    logic [47:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         last_g = NG - 1;
  logic [9:0] b_base [NG];
  logic [3:0] b_idx  [NG];

  // A row is the three words at base + idx*3 + k (mod 1024), word 0 in the MSBs.
  function automatic logic [47:0] row_of(input logic [9:0] base, input logic [3:0] idx);
    logic [47:0] r;
    int a;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      a = (int'(base) + int'(idx) * 3 + k) % 1024;
      r = {r[31:0], 16'(a)};
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_flats();
    for (int g = 0; g < NG; g++) begin
      rowIndexFlat[4*g +: 4] = b_idx[g];
      baseFlat[10*g +: 10]   = b_base[g];
    end
  endtask

  // Monitor: every rowValid pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rowValid !== '0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_row actual rowValid=%b rowData=%h required no pulse", rowValid, rowData);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("row_owner", 64'(rowValid), 64'(NG'(1) << e.g));
        chk("row_data", 64'(rowData), 64'(e.data));
      end
    end
  end

  // mode 0: plain burst; 1: overwrite the second-served glyph before its grant;
  // 2: re-request the first glyph in its own grant cycle.
  task automatic burst(input logic [NG-1:0] mask, input int mode);
    int order[$];
    int g0, g2, bound, t;
    logic [9:0] a0;
    logic [3:0] i0;
    exp_t e;
    for (int i = 1; i <= NG; i++) begin
      int g;
      g = (last_g + i) % NG;
      if (((mask >> g) & NG'(1)) != '0) order.push_back(g);
    end
    foreach (order[j]) begin
      e.g    = order[j];
      e.data = row_of(b_base[order[j]], b_idx[order[j]]);
      exp_q.push_back(e);
    end
    last_g = order[order.size()-1];
    g0 = order[0];
    a0 = b_base[g0];
    i0 = b_idx[g0];

    @(posedge clk); #1;
    set_flats();
    req = mask;
    @(posedge clk); #1;
    req = '0;
    // Now in the grant cycle of the first glyph.
    if (mode == 1 && order.size() >= 2) begin
      g2 = order[1];
      b_base[g2] = 10'($urandom_range(0, 1023));
      b_idx[g2]  = 4'($urandom_range(0, 15));
      set_flats();
      req = NG'(1) << g2;
      exp_q[1].data = row_of(b_base[g2], b_idx[g2]);
    end else if (mode == 2) begin
      b_base[g0] = 10'($urandom_range(0, 1023));
      b_idx[g0]  = 4'($urandom_range(0, 15));
      set_flats();
      req = NG'(1) << g0;
      e.g    = g0;
      e.data = row_of(b_base[g0], b_idx[g0]);
      exp_q.push_back(e);
      last_g = g0;
    end
    @(negedge clk);
    chk("grant_busy", 64'(busy), 64'(0));
    chk("grant_addr", 64'(rom_addr), 64'(0));
    @(posedge clk); #1;
    req = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fetch_addr", 64'(rom_addr), 64'((int'(a0) + int'(i0) * 3 + k) % 1024));
      chk("fetch_busy", 64'(busy), 64'(1));
    end
    @(negedge clk);
    chk("drain_addr", 64'(rom_addr), 64'(0));
    chk("drain_busy", 64'(busy), 64'(1));
    @(negedge clk);
    chk("latency", 64'(rowValid), 64'(NG'(1) << g0));
    bound = 5 * exp_q.size() + 20;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk("drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    rowIndexFlat = '0;
    baseFlat = '0;
    for (int g = 0; g < NG; g++) begin
      b_base[g] = '0;
      b_idx[g]  = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_addr", 64'(rom_addr), 64'(0));
    chk("rst_valid", 64'(rowValid), 64'(0));
    chk("rst_data", 64'(rowData), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // All five at once from reset: served 0,1,2,3,4.
    for (int g = 0; g < NG; g++) begin
      b_base[g] = 10'(16 * g);
      b_idx[g]  = 4'd0;
    end
    burst(5'b11111, 0);

    // Glyph 0 served, then 0 and 3 together: 3 must come first.
    burst(5'b00001, 0);
    b_base[0] = 10'h123; b_idx[0] = 4'd7;
    b_base[3] = 10'h2A0; b_idx[3] = 4'd9;
    burst(5'b01001, 0);

    // Single glyph, known addresses 01F,020,021.
    b_base[2] = 10'h010; b_idx[2] = 4'd5;
    burst(5'b00100, 0);

    // Address wrap 3FF -> 000 -> 001.
    b_base[1] = 10'h3FF; b_idx[1] = 4'd0;
    burst(5'b00010, 0);

    // Randomized bursts, including overwrite and same-cycle re-request cases.
    for (int n = 0; n < 40; n++) begin
      for (int g = 0; g < NG; g++) begin
        b_base[g] = 10'($urandom_range(0, 1023));
        b_idx[g]  = 4'($urandom_range(0, 15));
      end
      burst(NG'($urandom_range(1, (1 << NG) - 1)), int'($urandom_range(0, 2)));
    end

    // Reset in the third address cycle of a fetch: nothing may come out afterwards.
    b_base[0] = 10'h055; b_idx[0] = 4'd1;
    b_base[1] = 10'h066; b_idx[1] = 4'd2;
    @(posedge clk); #1;
    set_flats();
    req = 5'b00011;
    @(posedge clk); #1;
    req = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_g = NG - 1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_addr", 64'(rom_addr), 64'(0));
    chk("post_rst_valid", 64'(rowValid), 64'(0));
    repeat (20) begin
      @(negedge clk);
      chk("dropped_busy", 64'(busy), 64'(0));
    end

    // Normal service resumes, round-robin restarting at glyph 0.
    for (int g = 0; g < NG; g++) begin
      b_base[g] = 10'($urandom_range(0, 1023));
      b_idx[g]  = 4'($urandom_range(0, 15));
    end
    burst(5'b10110, 0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
